// File: rtl/obi_spi_master_arbiter_if.sv
// OBI bus bundle between the two requesters, the arbiter and the interconnect.
// The master modport is the arbiter's view; slave is the surrounding environment.
interface obi_spi_master_arbiter_if #(
  parameter int OBI_ADDR_WIDTH = 32,
  parameter int OBI_DATA_WIDTH = 32
);
  logic [1:0]                  s_req;
  logic [1:0]                  s_gnt;
  logic [2*OBI_ADDR_WIDTH-1:0] s_addr;
  logic [1:0]                  s_we;
  logic [2*OBI_DATA_WIDTH-1:0] s_w_data;
  logic [7:0]                  s_be;
  logic [1:0]                  s_r_valid;
  logic [OBI_DATA_WIDTH-1:0]   s_r_data;
  logic                        m_req;
  logic                        m_gnt;
  logic [OBI_ADDR_WIDTH-1:0]   m_addr;
  logic                        m_we;
  logic [OBI_DATA_WIDTH-1:0]   m_w_data;
  logic [3:0]                  m_be;
  logic                        m_r_valid;
  logic [OBI_DATA_WIDTH-1:0]   m_r_data;

  modport master (
    input  s_req, s_addr, s_we, s_w_data, s_be, m_gnt, m_r_valid, m_r_data,
    output s_gnt, s_r_valid, s_r_data, m_req, m_addr, m_we, m_w_data, m_be
  );

  modport slave (
    output s_req, s_addr, s_we, s_w_data, s_be, m_gnt, m_r_valid, m_r_data,
    input  s_gnt, s_r_valid, s_r_data, m_req, m_addr, m_we, m_w_data, m_be
  );
endinterface

// File: rtl/obi_spi_master_arbiter.sv
// Round-robin arbiter sharing one OBI master port between the SPI slave plug (0)
// and a second on-chip master (1), with in-order response routing via an ID FIFO.
module obi_spi_master_arbiter #(
  parameter int OBI_ADDR_WIDTH  = 32,
  parameter int OBI_DATA_WIDTH  = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic obi_aclk,
  input  logic obi_areset,
  obi_spi_master_arbiter_if.master bus,
  output logic err_unexp_rvalid,
  output logic busy
);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;

  logic                       sel_q, sel_d;
  logic                       lock_q, lock_d;
  logic                       rrPrio_q, rrPrio_d;
  logic                       err_q, err_d;
  logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
  logic [PW-1:0]              wptr_q, wptr_d;
  logic [PW-1:0]              rptr_q, rptr_d;
  logic [CW-1:0]              count_q, count_d;

  logic selEff;
  logic full;
  logic handshake;
  logic pop;
  logic headId;

  // A locked address phase keeps its owner until granted; otherwise pick the sole
  // requester, the round-robin favourite on contention, or hold when idle.
  always_comb begin
    selEff = sel_q;
    if (!lock_q) begin
      case (bus.s_req)
        2'b01:   selEff = 1'b0;
        2'b10:   selEff = 1'b1;
        2'b11:   selEff = rrPrio_q;
        default: selEff = sel_q;
      endcase
    end
  end

  assign full      = (count_q == CW'(MAX_OUTSTANDING));
  assign bus.m_req = bus.s_req[selEff] & ~full & ~obi_areset;
  assign handshake = bus.m_req & bus.m_gnt;
  assign pop       = bus.m_r_valid & (count_q != '0);
  assign headId    = fifo_q[rptr_q];

  assign bus.s_gnt     = {handshake & selEff, handshake & ~selEff};
  assign bus.s_r_valid = {pop & headId & ~obi_areset, pop & ~headId & ~obi_areset};
  assign bus.s_r_data  = bus.m_r_data;

  assign bus.m_addr   = selEff ? bus.s_addr[OBI_ADDR_WIDTH +: OBI_ADDR_WIDTH]
                               : bus.s_addr[0 +: OBI_ADDR_WIDTH];
  assign bus.m_w_data = selEff ? bus.s_w_data[OBI_DATA_WIDTH +: OBI_DATA_WIDTH]
                               : bus.s_w_data[0 +: OBI_DATA_WIDTH];
  assign bus.m_we     = bus.s_we[selEff];
  assign bus.m_be     = selEff ? bus.s_be[7:4] : bus.s_be[3:0];

  assign err_unexp_rvalid = err_q;
  assign busy             = bus.m_req | (count_q != '0);

  always_comb begin
    sel_d    = selEff;
    lock_d   = bus.m_req & ~bus.m_gnt;
    rrPrio_d = handshake ? ~selEff : rrPrio_q;
    err_d    = err_q | (bus.m_r_valid & (count_q == '0));
    fifo_d   = fifo_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    if (handshake) begin
      fifo_d[wptr_q] = selEff;
      wptr_d         = wptr_q + PW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PW'(1);
    end
    case ({handshake, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge obi_aclk or posedge obi_areset) begin
    if (obi_areset) begin
      sel_q    <= 1'b0;
      lock_q   <= 1'b0;
      rrPrio_q <= 1'b0;
      err_q    <= 1'b0;
      fifo_q   <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
    end else begin
      sel_q    <= sel_d;
      lock_q   <= lock_d;
      rrPrio_q <= rrPrio_d;
      err_q    <= err_d;
      fifo_q   <= fifo_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: tb/tb_obi_spi_master_arbiter.sv
// Directed, table-driven bench for the two-port OBI arbiter plus hand-written
// sequences for back-pressure when full, sticky error and mid-transfer reset.
module tb_obi_spi_master_arbiter;
  localparam logic [31:0] ADDR0 = 32'h1A10_0000;
  localparam logic [31:0] ADDR1 = 32'h2000_0040;
  localparam logic [31:0] WDAT0 = 32'hDEAD_0000;
  localparam logic [31:0] WDAT1 = 32'hBEEF_0001;
  localparam logic [3:0]  BE0   = 4'hF;
  localparam logic [3:0]  BE1   = 4'h3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic errUnexp;
  logic busyOut;
  int   vecCount  = 0;
  int   missCount = 0;

  always #5 clk = ~clk;

  obi_spi_master_arbiter_if #(.OBI_ADDR_WIDTH(32), .OBI_DATA_WIDTH(32)) bus ();

  obi_spi_master_arbiter #(
    .OBI_ADDR_WIDTH(32), .OBI_DATA_WIDTH(32), .MAX_OUTSTANDING(4)
  ) dut (
    .obi_aclk(clk),
    .obi_areset(rst),
    .bus(bus),
    .err_unexp_rvalid(errUnexp),
    .busy(busyOut)
  );

  typedef struct packed {
    logic [1:0]  req;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        expReq;
    logic [1:0]  expGnt;
    logic [1:0]  expRv;
    logic        expSel;
    logic        expBusy;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mkVec(logic [1:0] req, logic gnt, logic rv, logic [31:0] rdata,
                                 logic expReq, logic [1:0] expGnt, logic [1:0] expRv,
                                 logic expSel, logic expBusy);
    vec_t v;
    v.req = req; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
    v.expReq = expReq; v.expGnt = expGnt; v.expRv = expRv;
    v.expSel = expSel; v.expBusy = expBusy;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change on the falling edge and outputs are sampled 2ns later,
  // well clear of the rising edge that commits state.
  task automatic applyStimulus(input logic [1:0] req, input logic gnt, input logic rv,
                               input logic [31:0] rdata);
    @(negedge clk);
    bus.s_req     = req;
    bus.m_gnt     = gnt;
    bus.m_r_valid = rv;
    bus.m_r_data  = rdata;
    #2;
  endtask

  initial begin
    bus.s_addr    = {ADDR1, ADDR0};
    bus.s_w_data  = {WDAT1, WDAT0};
    bus.s_we      = 2'b01;
    bus.s_be      = {BE1, BE0};
    bus.s_req     = 2'b11;
    bus.m_gnt     = 1'b1;
    bus.m_r_valid = 1'b0;
    bus.m_r_data  = '0;

    #2;
    checkOutput("rst_m_req", 32'(bus.m_req), 32'd0);
    checkOutput("rst_s_gnt", 32'(bus.s_gnt), 32'd0);
    checkOutput("rst_err", 32'(errUnexp), 32'd0);
    @(negedge clk);
    bus.s_req = 2'b00;
    rst = 1'b0;
    #2;
    checkOutput("rst_busy", 32'(busyOut), 32'd0);

    // Alternating grants from reset, requester-0 single transfer, locked
    // address phase, then grant order 0,1,1,0 with four queued responses.
    vecs[0]  = mkVec(2'b11, 1, 0, 32'h0,     1, 2'b01, 2'b00, 0, 1);
    vecs[1]  = mkVec(2'b11, 1, 1, 32'h100,   1, 2'b10, 2'b01, 1, 1);
    vecs[2]  = mkVec(2'b11, 1, 1, 32'h101,   1, 2'b01, 2'b10, 0, 1);
    vecs[3]  = mkVec(2'b11, 1, 1, 32'h102,   1, 2'b10, 2'b01, 1, 1);
    vecs[4]  = mkVec(2'b00, 0, 1, 32'h103,   0, 2'b00, 2'b10, 0, 1);
    vecs[5]  = mkVec(2'b01, 1, 0, 32'h0,     1, 2'b01, 2'b00, 0, 1);
    vecs[6]  = mkVec(2'b00, 0, 1, 32'h1234,  0, 2'b00, 2'b01, 0, 1);
    vecs[7]  = mkVec(2'b10, 0, 0, 32'h0,     1, 2'b00, 2'b00, 1, 1);
    vecs[8]  = mkVec(2'b11, 0, 0, 32'h0,     1, 2'b00, 2'b00, 1, 1);
    vecs[9]  = mkVec(2'b11, 0, 0, 32'h0,     1, 2'b00, 2'b00, 1, 1);
    vecs[10] = mkVec(2'b11, 1, 0, 32'h0,     1, 2'b10, 2'b00, 1, 1);
    vecs[11] = mkVec(2'b01, 1, 1, 32'h55,    1, 2'b01, 2'b10, 0, 1);
    vecs[12] = mkVec(2'b00, 0, 1, 32'h66,    0, 2'b00, 2'b01, 0, 1);
    vecs[13] = mkVec(2'b01, 1, 0, 32'h0,     1, 2'b01, 2'b00, 0, 1);
    vecs[14] = mkVec(2'b10, 1, 0, 32'h0,     1, 2'b10, 2'b00, 1, 1);
    vecs[15] = mkVec(2'b10, 1, 0, 32'h0,     1, 2'b10, 2'b00, 1, 1);
    vecs[16] = mkVec(2'b01, 1, 0, 32'h0,     1, 2'b01, 2'b00, 0, 1);
    vecs[17] = mkVec(2'b00, 0, 1, 32'hA,     0, 2'b00, 2'b01, 0, 1);
    vecs[18] = mkVec(2'b00, 0, 1, 32'hB,     0, 2'b00, 2'b10, 0, 1);
    vecs[19] = mkVec(2'b00, 0, 1, 32'hC,     0, 2'b00, 2'b10, 0, 1);
    vecs[20] = mkVec(2'b00, 0, 1, 32'hD,     0, 2'b00, 2'b01, 0, 1);
    vecs[21] = mkVec(2'b00, 0, 0, 32'h0,     0, 2'b00, 2'b00, 0, 0);

    for (int i = 0; i < 22; i++) begin
      applyStimulus(vecs[i].req, vecs[i].gnt, vecs[i].rv, vecs[i].rdata);
      checkOutput($sformatf("v%0d_m_req", i), 32'(bus.m_req), 32'(vecs[i].expReq));
      checkOutput($sformatf("v%0d_s_gnt", i), 32'(bus.s_gnt), 32'(vecs[i].expGnt));
      checkOutput($sformatf("v%0d_s_r_valid", i), 32'(bus.s_r_valid), 32'(vecs[i].expRv));
      checkOutput($sformatf("v%0d_busy", i), 32'(busyOut), 32'(vecs[i].expBusy));
      checkOutput($sformatf("v%0d_err", i), 32'(errUnexp), 32'd0);
      if (vecs[i].expRv != 2'b00)
        checkOutput($sformatf("v%0d_s_r_data", i), bus.s_r_data, vecs[i].rdata);
      if (vecs[i].expReq) begin
        checkOutput($sformatf("v%0d_m_addr", i), bus.m_addr, vecs[i].expSel ? ADDR1 : ADDR0);
        checkOutput($sformatf("v%0d_m_w_data", i), bus.m_w_data, vecs[i].expSel ? WDAT1 : WDAT0);
        checkOutput($sformatf("v%0d_m_we", i), 32'(bus.m_we), vecs[i].expSel ? 32'd0 : 32'd1);
        checkOutput($sformatf("v%0d_m_be", i), 32'(bus.m_be), vecs[i].expSel ? 32'(BE1) : 32'(BE0));
      end
    end

    // Four grants fill the ID FIFO; the fifth request must be held off even
    // through the cycle of the first response.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'b01, 1, 0, 32'h0);
      checkOutput($sformatf("fill%0d_s_gnt", i), 32'(bus.s_gnt), 32'd1);
    end
    applyStimulus(2'b01, 1, 0, 32'h0);
    checkOutput("full_m_req", 32'(bus.m_req), 32'd0);
    checkOutput("full_s_gnt", 32'(bus.s_gnt), 32'd0);
    checkOutput("full_busy", 32'(busyOut), 32'd1);
    applyStimulus(2'b01, 1, 1, 32'h77);
    checkOutput("full_pop_m_req", 32'(bus.m_req), 32'd0);
    checkOutput("full_pop_s_r_valid", 32'(bus.s_r_valid), 32'd1);
    applyStimulus(2'b01, 0, 0, 32'h0);
    checkOutput("after_pop_m_req", 32'(bus.m_req), 32'd1);
    applyStimulus(2'b01, 1, 0, 32'h0);
    checkOutput("refill_s_gnt", 32'(bus.s_gnt), 32'd1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'b00, 0, 1, 32'h200 + 32'(i));
      checkOutput($sformatf("drain%0d_s_r_valid", i), 32'(bus.s_r_valid), 32'd1);
    end
    applyStimulus(2'b00, 0, 0, 32'h0);
    checkOutput("drained_busy", 32'(busyOut), 32'd0);

    // Stray response sets the sticky error; reset with two outstanding clears it.
    applyStimulus(2'b00, 0, 1, 32'hBAD);
    checkOutput("stray_s_r_valid", 32'(bus.s_r_valid), 32'd0);
    applyStimulus(2'b00, 0, 0, 32'h0);
    checkOutput("stray_err_set", 32'(errUnexp), 32'd1);
    applyStimulus(2'b01, 1, 0, 32'h0);
    checkOutput("err_held", 32'(errUnexp), 32'd1);
    applyStimulus(2'b01, 1, 0, 32'h0);
    checkOutput("pre_rst_s_gnt", 32'(bus.s_gnt), 32'd1);
    @(negedge clk);
    bus.s_req = 2'b11;
    bus.m_gnt = 1'b0;
    rst = 1'b1;
    #2;
    checkOutput("mid_rst_m_req", 32'(bus.m_req), 32'd0);
    checkOutput("mid_rst_s_gnt", 32'(bus.s_gnt), 32'd0);
    checkOutput("mid_rst_err", 32'(errUnexp), 32'd0);
    checkOutput("mid_rst_busy", 32'(busyOut), 32'd0);
    @(negedge clk);
    bus.s_req = 2'b00;
    rst = 1'b0;
    #2;
    checkOutput("post_rst_busy", 32'(busyOut), 32'd0);
    applyStimulus(2'b00, 0, 1, 32'hBAD);
    checkOutput("post_rst_stray_s_r_valid", 32'(bus.s_r_valid), 32'd0);
    applyStimulus(2'b00, 0, 0, 32'h0);
    checkOutput("post_rst_err", 32'(errUnexp), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end
endmodule
